vic_ctrl: RTL and testbench

VIC_CTRL -- requirements
Module: vic_ctrl

---
 rtl/vic_ctrl.sv | 75 +++++++
 tb/tb_vic_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vic_ctrl.sv
// vic_ctrl: vectored interrupt controller with fixed-priority sources and a trap bypass.
// Ports: clk, reset (async, active-high); cs/addr/wdata/wstrb/rdata CPU register window;
//        src[3:0] interrupt sources; trap CPU trap request; irq/ivector[29:0] to the CPU.
// Build option: VIC_EDGE_CAPTURE_EN selects edge-captured requests instead of level requests.
module vic_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  input  logic [3:0]  src,
  input  logic        trap,
  output logic        irq,
  output logic [29:0] ivector
);
  logic [3:0]  irqen_q, irqen_d;
  logic [29:0] tbl_q [5];
  logic [29:0] tbl_d [5];
  logic        irq_q, irq_d;
  logic [29:0] ivec_q, ivec_d;
  logic [3:0]  req, pend, latch;
  logic        wr;
  assign wr = cs && wstrb != 4'b0000;
`ifdef VIC_EDGE_CAPTURE_EN
  logic [3:0] latch_q, latch_d, prev_q;
  // a set in the same cycle as a clear wins because it is OR-ed in last
  assign latch_d = (latch_q & ~((wr && addr == 3'd1 && wstrb[0]) ? wdata[3:0] : 4'b0000)) | (src & ~prev_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      latch_q <= '0;
      prev_q  <= '0;
    end else begin
      latch_q <= latch_d;
      prev_q  <= src;
    end
  assign latch = latch_q;
  assign req   = latch_q;
`else
  assign latch = '0;
  assign req   = src;
`endif
  // table slots: 0 = trap, 1..4 = handlers for src[0]..src[3]
  always_comb begin
    irqen_d = (wr && addr == 3'd0 && wstrb[0]) ? wdata[3:0] : irqen_q;
    tbl_d   = tbl_q;
    if (cs && wstrb == 4'b1111) begin
      if (addr == 3'd2) tbl_d[4] = wdata[31:2];
      else if (addr[2]) tbl_d[addr[1:0]] = wdata[31:2];
    end
    pend   = irqen_q & req;
    irq_d  = |pend;
    ivec_d = pend[0] ? tbl_q[1] : pend[1] ? tbl_q[2] : pend[2] ? tbl_q[3] : pend[3] ? tbl_q[4] : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      irqen_q <= '0;
      for (int k = 0; k < 5; k++) tbl_q[k] <= '0;
      irq_q   <= 1'b0;
      ivec_q  <= '0;
    end else begin
      irqen_q <= irqen_d;
      tbl_q   <= tbl_d;
      irq_q   <= irq_d;
      ivec_q  <= ivec_d;
    end
  assign rdata = (!cs || wstrb != 4'b0000) ? 32'h0 :
                 addr == 3'd0 ? {28'h0, irqen_q} :
                 addr == 3'd1 ? {24'h0, latch, src} :
                 addr == 3'd2 ? {tbl_q[4], 2'b00} :
                 addr == 3'd3 ? 32'h0 : {tbl_q[addr[1:0]], 2'b00};
  assign irq     = irq_q | trap;
  assign ivector = trap ? tbl_q[0] : ivec_q;
endmodule

// File: tb/tb_vic_ctrl.sv
// tb_vic_ctrl: scoreboard bench for vic_ctrl against a cycle-level behavioural model.
module tb_vic_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1, cs = 1'b0, trap = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0, src = '0;
  logic        irq;
  logic [29:0] ivector;

  vic_ctrl dut (.clk(clk), .reset(reset), .cs(cs), .addr(addr), .wdata(wdata), .wstrb(wstrb),
                .rdata(rdata), .src(src), .trap(trap), .irq(irq), .ivector(ivector));

  always #5 clk = ~clk;

`ifdef VIC_EDGE_CAPTURE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct packed {logic irq; logic [29:0] iv; logic [31:0] rd;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [3:0] s_src = '0;

  // model state: enables, five handler words (0 = trap, i+1 = source i), latches, registered outputs
  logic [3:0]  m_en, m_latch, m_prev;
  logic [29:0] m_vec [5];
  logic        m_irq;
  logic [29:0] m_iv;

  function automatic void m_clear();
    m_en = 0; m_latch = 0; m_prev = 0; m_irq = 0; m_iv = 0;
    for (int k = 0; k < 5; k++) m_vec[k] = 0;
  endfunction

  function automatic logic [31:0] m_read();
    if (!cs || wstrb != 0) return 0;
    case (addr)
      3'd0: return {28'h0, m_en};
      3'd1: return {24'h0, m_latch, src};
      3'd2: return {m_vec[4], 2'b00};
      3'd3: return 0;
      default: return {m_vec[int'(addr) - 4], 2'b00};
    endcase
  endfunction

  function automatic void m_step();
    logic [3:0] pend;
    int sel = -1;
    pend = m_en & (EDGE ? m_latch : src);
    for (int i = 3; i >= 0; i--) if (pend[i]) sel = i;
    m_irq = sel >= 0;
    m_iv  = sel >= 0 ? m_vec[sel + 1] : '0;
    if (cs && wstrb != 0) begin
      if (addr == 0 && wstrb[0]) m_en = wdata[3:0];
      if (wstrb == 4'hF && addr == 2) m_vec[4] = wdata[31:2];
      if (wstrb == 4'hF && addr >= 4) m_vec[int'(addr) - 4] = wdata[31:2];
      if (EDGE && addr == 1 && wstrb[0]) m_latch = m_latch & ~wdata[3:0];
    end
    if (EDGE) begin
      for (int i = 0; i < 4; i++) if (src[i] && !m_prev[i]) m_latch[i] = 1'b1;
      m_prev = src;
    end
  endfunction

  task automatic cyc(input logic r, input logic c, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [3:0] sr, input logic t);
    @(negedge clk);
    reset = r; cs = c; addr = a; wdata = d; wstrb = s; src = sr; trap = t;
    if (r) m_clear();
    q.push_back(exp_t'{m_irq | t, t ? m_vec[0] : m_iv, m_read()});
    if (!r) m_step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc(0, 1, a, d, s, s_src, 0);
  endtask
  task automatic rd(input logic [2:0] a);
    cyc(0, 1, a, 0, 0, s_src, 0);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, s_src, 0);
  endtask

  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("irq", {31'h0, irq}, {31'h0, e.irq});
        chk("ivector", {2'b00, ivector}, {2'b00, e.iv});
        chk("rdata", rdata, e.rd);
      end
    end
  end

  initial begin
    logic [3:0] s;
    m_clear();
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();
    wr(0, 32'hF, 4'h1); wr(5, 32'h100, 4'hF); wr(6, 32'h200, 4'hF);
    s_src = 4'b0011; repeat (2) idle();
    s_src = 4'b0010; repeat (2) idle();
    wr(4, 32'h40, 4'hF); s_src = 4'b0001; repeat (2) idle();
    cyc(0, 0, 0, 0, 0, s_src, 1); repeat (2) idle();
    wr(0, 32'h7, 4'h1); s_src = 4'b1000; repeat (2) idle();
    wr(0, 32'h8, 4'h1); repeat (2) idle();
    wr(2, 32'h300, 4'hF); idle(); wr(2, 32'h999, 4'h3); idle(); rd(2); idle();
    wr(3, 32'hFFFFFFFF, 4'hF); rd(3); rd(0); rd(1);
    cyc(0, 0, 4, 0, 0, s_src, 0);
`ifdef VIC_EDGE_CAPTURE_EN
    wr(0, 32'h4, 4'h1); s_src = 4'b0100; idle(); s_src = 0; repeat (2) idle(); rd(1);
    wr(1, 32'h4, 4'h1); repeat (2) idle(); rd(1);
    cyc(0, 1, 1, 32'h4, 4'h1, 4'b0100, 0); s_src = 4'b0100; repeat (2) idle(); rd(1);
`endif
    wr(0, 32'hF, 4'h1); s_src = 4'hF; repeat (2) idle();
    cyc(1, 0, 0, 0, 0, s_src, 0); cyc(1, 0, 0, 0, 0, s_src, 0);
    idle(); rd(0); rd(2); rd(4); rd(5); rd(6); rd(7);
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 4))
        0, 1: s = 4'h0;
        2: s = 4'hF;
        3: s = 4'h1;
        default: s = 4'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) s_src = 4'($urandom);
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 3'($urandom), $urandom, s, s_src,
          $urandom_range(0, 9) == 0);
    end
    repeat (2) idle();
    @(negedge clk); #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
